// File: rtl/spad_stream_ctrl_if.sv
// Control, upstream/downstream stream and scratchpad signals of spad_stream_ctrl.
// SPAD_REUSE_EN adds the reuse count input and the pass_last output.
interface spad_stream_ctrl_if #(
    parameter int DATA_BITWIDTH = 8,
    parameter int ADDR_BITWIDTH = 4
) ();
    logic                     start;
    logic [ADDR_BITWIDTH:0]   len;
    logic                     busy;
    logic                     done;
    logic                     s_valid;
    logic                     s_ready;
    logic [DATA_BITWIDTH-1:0] s_data;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_BITWIDTH-1:0] m_data;
    logic                     rf_en;
    logic                     rf_we;
    logic [DATA_BITWIDTH-1:0] rf_din;
    logic [ADDR_BITWIDTH-1:0] rf_wr_addr;
    logic [ADDR_BITWIDTH-1:0] rf_rd_addr;
    logic [DATA_BITWIDTH-1:0] rf_dout;
`ifdef SPAD_REUSE_EN
    logic [7:0]               reuse;
    logic                     pass_last;
`endif

    modport master (
        input  start, len, s_valid, s_data, m_ready, rf_dout,
`ifdef SPAD_REUSE_EN
        input  reuse,
        output pass_last,
`endif
        output busy, done, s_ready, m_valid, m_data,
        output rf_en, rf_we, rf_din, rf_wr_addr, rf_rd_addr
    );

    modport slave (
        output start, len, s_valid, s_data, m_ready, rf_dout,
`ifdef SPAD_REUSE_EN
        output reuse,
        input  pass_last,
`endif
        input  busy, done, s_ready, m_valid, m_data,
        input  rf_en, rf_we, rf_din, rf_wr_addr, rf_rd_addr
    );
endinterface

// File: rtl/spad_stream_ctrl.sv
// Scratchpad fill/drain controller: writes a block from the upstream stream, then replays it downstream.
// Optional SPAD_REUSE_EN: replays the block max(reuse,1) times before done.
//
// state | meaning
// IDLE  | waiting for start with a non-zero len
// FILL  | accepting upstream words into addresses 0..len_q-1
// DRAIN | reading addresses 0..len_q-1 out to the downstream stream
module spad_stream_ctrl #(
    parameter int DATA_BITWIDTH = 8,
    parameter int ADDR_BITWIDTH = 4
) (
    input  logic               clk,
    input  logic               rstN,
    spad_stream_ctrl_if.master bus
);
    localparam int CW = ADDR_BITWIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_BITWIDTH;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0] len_q, len_d;
    logic          done_q, done_d;
    logic [CW-1:0] len_clamp;
    logic          last_rd;
`ifdef SPAD_REUSE_EN
    logic [7:0]    passes_m1_q, passes_m1_d;
    logic [7:0]    pass_q, pass_d;
    logic          final_pass;

    assign final_pass    = (pass_q == passes_m1_q);
    assign bus.pass_last = (state_q == DRAIN) && final_pass;
`endif

    assign len_clamp = (bus.len > DEPTH) ? DEPTH : bus.len;
    assign last_rd   = (rcnt_q == len_q - CW'(1));

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.s_ready    = (state_q == FILL);
    assign bus.rf_we      = (state_q == FILL) && bus.s_valid;
    assign bus.rf_din     = (state_q == FILL) ? bus.s_data : '0;
    assign bus.rf_wr_addr = (state_q == FILL) ? wcnt_q[ADDR_BITWIDTH-1:0] : '0;
    assign bus.rf_en      = (state_q == DRAIN);
    assign bus.m_valid    = (state_q == DRAIN);
    assign bus.m_data     = (state_q == DRAIN) ? bus.rf_dout : '0;
    assign bus.rf_rd_addr = (state_q == DRAIN) ? rcnt_q[ADDR_BITWIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            len_q       <= '0;
            done_q      <= 1'b0;
`ifdef SPAD_REUSE_EN
            passes_m1_q <= '0;
            pass_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            len_q       <= len_d;
            done_q      <= done_d;
`ifdef SPAD_REUSE_EN
            passes_m1_q <= passes_m1_d;
            pass_q      <= pass_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        len_d       = len_q;
        done_d      = 1'b0;
`ifdef SPAD_REUSE_EN
        passes_m1_d = passes_m1_q;
        pass_d      = pass_q;
`endif
        case (state_q)
            IDLE: begin
                // A zero-length start is dropped so no empty block ever reports done.
                if (bus.start && (bus.len != '0)) begin
                    len_d   = len_clamp;
                    wcnt_d  = '0;
                    state_d = FILL;
`ifdef SPAD_REUSE_EN
                    passes_m1_d = (bus.reuse == 8'd0) ? 8'd0 : bus.reuse - 8'd1;
                    pass_d      = '0;
`endif
                end
            end
            FILL: begin
                if (bus.s_valid) begin
                    wcnt_d = wcnt_q + CW'(1);
                    if (wcnt_q == len_q - CW'(1)) begin
                        rcnt_d  = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.m_ready) begin
                    if (last_rd) begin
`ifdef SPAD_REUSE_EN
                        if (!final_pass) begin
                            rcnt_d = '0;
                            pass_d = pass_q + 8'd1;
                        end else
`endif
                        begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        rcnt_d = rcnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spad_stream_ctrl.sv
// Bench for spad_stream_ctrl: directed blocks checked against a queue model of expected writes and drained words.
module tb_spad_stream_ctrl;
    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    spad_stream_ctrl_if #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(4)) bus ();
    spad_stream_ctrl #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(4)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.master)
    );

    logic [7:0] mem [16];
    always @(posedge clk) if (bus.rf_we) mem[bus.rf_wr_addr] <= bus.rf_din;
    assign bus.rf_dout = bus.rf_en ? mem[bus.rf_rd_addr] : 8'h00;

    typedef struct {int idx; int d; bit last;} rd_t;
    typedef struct {int a; int d;} wr_t;
    rd_t exp_m[$];
    wr_t exp_w[$];
    int  exp_done = 0;
    int  tests = 0;
    int  fails = 0;
    int  busy_cycles = 0;
    int  drained = 0;
    int  last_m = 0;
    int  c;
    logic [7:0] wbuf [16];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected traffic straight from the block rules: clamp, writes in order, passes of reads.
    task automatic model_begin(input int l, input int r);
        int lc, passes;
        lc = (l > 16) ? 16 : l;
        passes = (r == 0) ? 1 : r;
        for (int i = 0; i < lc; i++) exp_w.push_back('{a: i, d: wbuf[i]});
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < lc; i++)
                exp_m.push_back('{idx: i, d: wbuf[i], last: (p == passes - 1)});
        exp_done++;
    endtask

    task automatic do_start(input int l, input int r);
        bus.start = 1'b1;
        bus.len   = 5'(l);
`ifdef SPAD_REUSE_EN
        bus.reuse = 8'(r);
`else
        if (r < 0) bus.len = 5'(l);
`endif
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        int t;
        t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        @(negedge clk);
        while (!bus.s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("s_handshake_timeout", 0, 1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < maxc);
        if (!bus.done) chk("done_timeout", 0, 1);
    endtask

    task automatic finish_block(input string name);
        int cyc;
        wait_done(200, cyc);
        gap();
        chk({name, "_writes_left"}, exp_w.size(), 0);
        chk({name, "_reads_left"}, exp_m.size(), 0);
        chk({name, "_done_left"}, exp_done, 0);
    endtask

    always @(negedge clk) begin
        if (rstN) begin
            if (!bus.busy) begin
                chk("idle_quiet", {bus.s_ready, bus.m_valid, bus.rf_en, bus.rf_we}, 0);
                chk("idle_addr", {bus.rf_wr_addr, bus.rf_rd_addr}, 0);
            end else begin
                busy_cycles++;
            end
            chk("busy_done_excl", bus.busy & bus.done, 0);
            chk("we_en_excl", bus.rf_we & bus.rf_en, 0);
            if (bus.rf_we) begin
                if (exp_w.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    chk("wr_addr", bus.rf_wr_addr, exp_w[0].a);
                    chk("wr_data", bus.rf_din, exp_w[0].d);
                    void'(exp_w.pop_front());
                end
            end
            if (bus.m_valid) begin
                if (exp_m.size() == 0) chk("unexpected_m_valid", 1, 0);
                else begin
                    chk("m_data", bus.m_data, exp_m[0].d);
                    chk("rd_addr", bus.rf_rd_addr, exp_m[0].idx);
`ifdef SPAD_REUSE_EN
                    chk("pass_last", bus.pass_last, exp_m[0].last);
`endif
                    if (bus.m_ready) begin
                        last_m = bus.m_data;
                        drained++;
                        void'(exp_m.pop_front());
                    end
                end
            end
            if (bus.done) begin
                chk("done_expected", int'(exp_done > 0), 1);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
`ifdef SPAD_REUSE_EN
        bus.reuse = '0;
`endif
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_outputs", {bus.s_ready, bus.m_valid, bus.rf_en, bus.rf_we}, 0);
        @(posedge clk); #1;
        rstN = 1'b1;

        // Block of 4, back-to-back, no backpressure
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        model_begin(4, 1);
        busy_cycles = 0;
        drained = 0;
        do_start(4, 1);
        for (int i = 0; i < 4; i++) push_word(wbuf[i]);
        wait_done(20, c);
        chk("t1_done_latency", c, 5);
        gap();
        chk("t1_busy_cycles", busy_cycles, 8);
        chk("t1_last_word", last_m, 8'h44);
        chk("t1_drained", drained, 4);
        chk("t1_reads_left", exp_m.size(), 0);

        // Full depth, gapped source, downstream stall mid-drain
        for (int i = 0; i < 16; i++) wbuf[i] = 8'(i * 37 + 5);
        model_begin(16, 1);
        drained = 0;
        do_start(16, 1);
        for (int i = 0; i < 16; i++) begin
            push_word(wbuf[i]);
            if (i != 15) gap();
        end
        repeat (5) gap();
        bus.m_ready = 1'b0;
        repeat (3) gap();
        bus.m_ready = 1'b1;
        finish_block("t2");
        chk("t2_drained", drained, 16);

        // Zero length is ignored
        do_start(0, 1);
        repeat (4) begin
            @(negedge clk);
            chk("len0_idle", bus.busy, 0);
        end
        gap();

        // Oversized length clamps to depth
        for (int i = 0; i < 16; i++) wbuf[i] = 8'(255 - i * 3);
        model_begin(20, 1);
        chk("clamp_model_len", exp_m.size(), 16);
        busy_cycles = 0;
        drained = 0;
        do_start(20, 1);
        for (int i = 0; i < 16; i++) push_word(wbuf[i]);
        finish_block("t3");
        chk("t3_busy_cycles", busy_cycles, 32);
        chk("t3_drained", drained, 16);

        // Reset in the middle of a fill
        wbuf[0] = 8'hC1; wbuf[1] = 8'hC2; wbuf[2] = 8'hC3; wbuf[3] = 8'hC4;
        model_begin(4, 1);
        do_start(4, 1);
        push_word(wbuf[0]);
        push_word(wbuf[1]);
        #2 rstN = 1'b0;
        #1;
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_outputs", {bus.s_ready, bus.m_valid, bus.rf_en, bus.rf_we, bus.done}, 0);
        exp_w.delete();
        exp_m.delete();
        exp_done = 0;
        gap();
        rstN = 1'b1;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        model_begin(2, 1);
        do_start(2, 1);
        push_word(wbuf[0]);
        push_word(wbuf[1]);
        finish_block("t4");
        chk("t4_last_word", last_m, 8'h5A);

        // Start during FILL and DRAIN is ignored; start together with done is honoured
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
        model_begin(3, 1);
        do_start(3, 1);
        push_word(wbuf[0]);
        do_start(5, 1);
        push_word(wbuf[1]);
        push_word(wbuf[2]);
        bus.m_ready = 1'b0;
        do_start(7, 1);
        bus.m_ready = 1'b1;
        wait_done(20, c);
        wbuf[0] = 8'h9C; wbuf[1] = 8'h3E;
        model_begin(2, 1);
        bus.start = 1'b1;
        bus.len = 5'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        push_word(wbuf[0]);
        push_word(wbuf[1]);
        finish_block("t5");
        chk("t5_last_word", last_m, 8'h3E);

`ifdef SPAD_REUSE_EN
        wbuf[0] = 8'd7; wbuf[1] = 8'd8; wbuf[2] = 8'd9;
        model_begin(3, 2);
        chk("reuse_model_len", exp_m.size(), 6);
        drained = 0;
        do_start(3, 2);
        for (int i = 0; i < 3; i++) push_word(wbuf[i]);
        finish_block("reuse2");
        chk("reuse2_drained", drained, 6);
        chk("reuse2_last_word", last_m, 9);

        wbuf[0] = 8'h61; wbuf[1] = 8'h62;
        model_begin(2, 0);
        drained = 0;
        do_start(2, 0);
        push_word(wbuf[0]);
        push_word(wbuf[1]);
        finish_block("reuse0");
        chk("reuse0_drained", drained, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
